control_datapath_resp: RTL and testbench

//  Responder/datapath end of the sel1/sel2/mux1/done control interface.

---
 rtl/control_datapath_resp.sv | 161 ++++++++++++++++
 tb/tb_control_datapath_resp.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_datapath_resp.sv
`default_nettype none
// ============================================================================
//  Module      : control_datapath_resp
//  Description : Datapath responder for the sel1/sel2/mux1/done control
//                strobes. It captures operand A and operand B, computes
//                A op B and publishes the result. It also watches strobe
//                ordering and idle gaps, and raises a sticky error on any
//                protocol violation.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_datapath_resp #(
  parameter int WIDTH   = 8,
  parameter int OP      = 0,
  parameter int TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel1,
  input  logic             sel2,
  input  logic             mux1,
  input  logic             done,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH:0]   result,
  output logic             result_valid,
  output logic             seq_err,
  output logic [7:0]       seq_count
);

  localparam int c_GAP_W = $clog2(TIMEOUT + 1);
  // An idle cycle seen with the counter at this value is the one that times out.
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [c_GAP_W-1:0] r_gap;

  logic [2:0]   w_hot;
  logic         w_multi;
  logic         w_none;
  logic         w_timeout;
  logic         w_bad;
  logic [WIDTH:0] w_calc;

  assign w_hot     = 3'(sel1) + 3'(sel2) + 3'(mux1) + 3'(done);
  assign w_multi   = (w_hot > 3'd1);
  assign w_none    = (w_hot == 3'd0);
  assign w_timeout = w_none && (r_gap == c_GAP_LAST);

  // Operands are zero-extended by one bit so bit WIDTH holds carry or borrow.
  generate
    if (OP == 0) begin : g_add
      assign w_calc = {1'b0, r_a} + {1'b0, r_b};
    end else begin : g_sub
      assign w_calc = {1'b0, r_a} - {1'b0, r_b};
    end
  endgenerate

  // Decode whether the strobes seen this cycle break the protocol.
  always_comb begin
    w_bad = 1'b0;
    case (r_state)
      S_IDLE:    w_bad = sel2 | mux1 | done;
      S_LOAD_A:  w_bad = mux1 | done | w_timeout;
      S_LOAD_B:  w_bad = sel1 | done | w_timeout;
      S_COMPUTE: w_bad = sel1 | sel2 | w_timeout;
      // Once done drops, DONE behaves like IDLE: only sel1 is legal.
      S_DONE:    w_bad = ~done & (sel2 | mux1);
      default:   w_bad = 1'b0;
    endcase
    w_bad = w_bad | w_multi;
  end

  // Sequence FSM with operand/result registers, gap timer and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_gap        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      seq_err      <= 1'b0;
      seq_count    <= 8'd0;
    end else if (r_state != S_ERR) begin
      if (w_bad) begin
        r_state      <= S_ERR;
        seq_err      <= 1'b1;
        result_valid <= 1'b0;
        r_gap        <= '0;
      end else begin
        result_valid <= 1'b0;
        r_gap        <= '0;
        case (r_state)
          S_IDLE: begin
            if (sel1) begin
              r_a     <= data_in;
              r_state <= S_LOAD_A;
            end
          end
          S_LOAD_A: begin
            if (sel1) begin
              r_a <= data_in;
            end else if (sel2) begin
              r_b     <= data_in;
              r_state <= S_LOAD_B;
            end else begin
              r_gap <= r_gap + c_GAP_W'(1);
            end
          end
          S_LOAD_B: begin
            if (sel2) begin
              r_b <= data_in;
            end else if (mux1) begin
              result  <= w_calc;
              r_state <= S_COMPUTE;
            end else begin
              r_gap <= r_gap + c_GAP_W'(1);
            end
          end
          S_COMPUTE: begin
            if (mux1) begin
              result <= w_calc;
            end else if (done) begin
              r_state      <= S_DONE;
              result_valid <= 1'b1;
              seq_count    <= seq_count + 8'd1;
            end else begin
              r_gap <= r_gap + c_GAP_W'(1);
            end
          end
          S_DONE: begin
            if (done) begin
              result_valid <= 1'b1;
            end else if (sel1) begin
              r_a     <= data_in;
              r_state <= S_LOAD_A;
            end else begin
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_state <= S_ERR;
            seq_err <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_datapath_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_datapath_resp
//  Description : Self-checking bench for control_datapath_resp. An adder
//                instance and a subtractor instance share one stimulus
//                stream; directed vectors and random traffic are compared
//                against expected values and a behavioural sequence model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_datapath_resp;

  localparam int c_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       r_rst = 1'b1;
  logic       r_sel1 = 1'b0;
  logic       r_sel2 = 1'b0;
  logic       r_mux1 = 1'b0;
  logic       r_done = 1'b0;
  logic [7:0] r_data = 8'd0;

  logic [8:0] w_res0, w_res1;
  logic       w_v0, w_v1, w_e0, w_e1;
  logic [7:0] w_c0, w_c1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_datapath_resp #(.WIDTH(8), .OP(0), .TIMEOUT(c_TIMEOUT)) u_add (
    .clk(clk), .rst(r_rst), .sel1(r_sel1), .sel2(r_sel2), .mux1(r_mux1),
    .done(r_done), .data_in(r_data), .result(w_res0), .result_valid(w_v0),
    .seq_err(w_e0), .seq_count(w_c0)
  );

  control_datapath_resp #(.WIDTH(8), .OP(1), .TIMEOUT(c_TIMEOUT)) u_sub (
    .clk(clk), .rst(r_rst), .sel1(r_sel1), .sel2(r_sel2), .mux1(r_mux1),
    .done(r_done), .data_in(r_data), .result(w_res1), .result_valid(w_v1),
    .seq_err(w_e1), .seq_count(w_c1)
  );

  // Behavioural model: phase 0 waiting for A, 1 have A, 2 have B,
  // 3 result computed, 4 publishing, 5 dead until reset.
  int         m_ph;
  int         m_gap;
  int         m_a, m_b;
  logic [8:0] m_r0, m_r1;
  logic       m_v, m_e;
  logic [7:0] m_c;

  task automatic model_step(input logic r, s1, s2, m, d, input logic [7:0] dat);
    int n;
    int ph;
    logic bad;
    if (r) begin
      m_ph = 0; m_gap = 0; m_a = 0; m_b = 0;
      m_r0 = '0; m_r1 = '0; m_v = 1'b0; m_e = 1'b0; m_c = 8'd0;
      return;
    end
    if (m_ph == 5) return;
    n = 0;
    if (s1) n++;
    if (s2) n++;
    if (m)  n++;
    if (d)  n++;
    bad = 1'b0;
    if (n > 1) begin
      bad = 1'b1;
    end else if (m_ph == 4 && d) begin
      m_v = 1'b1;
    end else begin
      ph = (m_ph == 4) ? 0 : m_ph;
      case (ph)
        0: if (s1) begin m_a = int'(dat); ph = 1; end else if (n != 0) bad = 1'b1;
        1: if (s1) m_a = int'(dat);
           else if (s2) begin m_b = int'(dat); ph = 2; end
           else if (n != 0) bad = 1'b1;
        2: if (s2) m_b = int'(dat);
           else if (m) begin
             m_r0 = 9'(m_a + m_b); m_r1 = 9'((m_a - m_b + 512) % 512); ph = 3;
           end else if (n != 0) bad = 1'b1;
        default: if (m) begin
             m_r0 = 9'(m_a + m_b); m_r1 = 9'((m_a - m_b + 512) % 512);
           end else if (d) begin ph = 4; m_c = m_c + 8'd1; end
           else if (n != 0) bad = 1'b1;
      endcase
      if (n == 0 && ph >= 1 && ph <= 3) begin
        m_gap++;
        if (m_gap >= c_TIMEOUT) bad = 1'b1;
      end else begin
        m_gap = 0;
      end
      m_ph = ph;
      m_v  = (ph == 4);
    end
    if (bad) begin
      m_ph = 5; m_e = 1'b1; m_v = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle, advance the model on the edge, compare shortly after.
  task automatic cyc(input logic r, s1, s2, m, d, input logic [7:0] dat);
    @(negedge clk);
    r_rst = r; r_sel1 = s1; r_sel2 = s2; r_mux1 = m; r_done = d; r_data = dat;
    @(posedge clk);
    model_step(r, s1, s2, m, d, dat);
    #1;
    chk("model_res_add", w_res0, m_r0);
    chk("model_res_sub", w_res1, m_r1);
    chk("model_valid_add", {8'd0, w_v0}, {8'd0, m_v});
    chk("model_valid_sub", {8'd0, w_v1}, {8'd0, m_v});
    chk("model_err_add", {8'd0, w_e0}, {8'd0, m_e});
    chk("model_err_sub", {8'd0, w_e1}, {8'd0, m_e});
    chk("model_cnt_add", {1'b0, w_c0}, {1'b0, m_c});
    chk("model_cnt_sub", {1'b0, w_c1}, {1'b0, m_c});
  endtask

  typedef struct {
    logic       rst, s1, s2, m, d;
    logic [7:0] dat;
    logic [8:0] r0, r1;
    logic       v, e;
    logic [7:0] c;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, s1, s2, m, d, input logic [7:0] dat,
                     input logic [8:0] r0, r1, input logic v, e, input logic [7:0] c);
    vec_t t;
    t.rst = r; t.s1 = s1; t.s2 = s2; t.m = m; t.d = d; t.dat = dat;
    t.r0 = r0; t.r1 = r1; t.v = v; t.e = e; t.c = c;
    tbl.push_back(t);
  endtask

  initial begin
    logic       s1, s2, mm, dd, rr;
    logic [3:0] mh;
    int         k;

    // Reset with strobes active
    add(1,1,1,1,1,8'hFF, 9'h000,9'h000,0,0,8'd0);
    add(1,1,0,1,0,8'h3C, 9'h000,9'h000,0,0,8'd0);
    // 0xC8 + 0x64, done held three cycles
    add(0,1,0,0,0,8'hC8, 9'h000,9'h000,0,0,8'd0);
    add(0,0,1,0,0,8'h64, 9'h000,9'h000,0,0,8'd0);
    add(0,0,0,1,0,8'h00, 9'h12C,9'h064,0,0,8'd0);
    add(0,0,0,0,1,8'h00, 9'h12C,9'h064,1,0,8'd1);
    add(0,0,0,0,1,8'h00, 9'h12C,9'h064,1,0,8'd1);
    add(0,0,0,0,1,8'h00, 9'h12C,9'h064,1,0,8'd1);
    add(0,0,0,0,0,8'h00, 9'h12C,9'h064,0,0,8'd1);
    // 0x10 op 0x20 (borrow), then 0x20 op 0x10
    add(0,1,0,0,0,8'h10, 9'h12C,9'h064,0,0,8'd1);
    add(0,0,1,0,0,8'h20, 9'h12C,9'h064,0,0,8'd1);
    add(0,0,0,1,0,8'h00, 9'h030,9'h1F0,0,0,8'd1);
    add(0,0,0,0,1,8'h00, 9'h030,9'h1F0,1,0,8'd2);
    add(0,0,0,0,0,8'h00, 9'h030,9'h1F0,0,0,8'd2);
    add(0,1,0,0,0,8'h20, 9'h030,9'h1F0,0,0,8'd2);
    add(0,0,1,0,0,8'h10, 9'h030,9'h1F0,0,0,8'd2);
    add(0,0,0,1,0,8'h00, 9'h030,9'h010,0,0,8'd2);
    add(0,0,0,0,1,8'h00, 9'h030,9'h010,1,0,8'd3);
    add(0,0,0,0,0,8'h00, 9'h030,9'h010,0,0,8'd3);
    // sel2 skipped: sticky error, later good sequence ignored
    add(0,1,0,0,0,8'h55, 9'h030,9'h010,0,0,8'd3);
    add(0,0,0,1,0,8'h00, 9'h030,9'h010,0,1,8'd3);
    add(0,1,0,0,0,8'h01, 9'h030,9'h010,0,1,8'd3);
    add(0,0,1,0,0,8'h02, 9'h030,9'h010,0,1,8'd3);
    add(0,0,0,1,0,8'h00, 9'h030,9'h010,0,1,8'd3);
    add(0,0,0,0,1,8'h00, 9'h030,9'h010,0,1,8'd3);
    add(1,0,0,0,0,8'h00, 9'h000,9'h000,0,0,8'd0);
    // Three idle cycles tolerated
    add(0,1,0,0,0,8'hAA, 9'h000,9'h000,0,0,8'd0);
    add(0,0,0,0,0,8'h00, 9'h000,9'h000,0,0,8'd0);
    add(0,0,0,0,0,8'h00, 9'h000,9'h000,0,0,8'd0);
    add(0,0,0,0,0,8'h00, 9'h000,9'h000,0,0,8'd0);
    add(0,0,1,0,0,8'hBB, 9'h000,9'h000,0,0,8'd0);
    add(0,0,0,1,0,8'h00, 9'h165,9'h1EF,0,0,8'd0);
    add(0,0,0,0,1,8'h00, 9'h165,9'h1EF,1,0,8'd1);
    add(0,0,0,0,0,8'h00, 9'h165,9'h1EF,0,0,8'd1);
    // Four idle cycles time out
    add(0,1,0,0,0,8'h01, 9'h165,9'h1EF,0,0,8'd1);
    add(0,0,0,0,0,8'h00, 9'h165,9'h1EF,0,0,8'd1);
    add(0,0,0,0,0,8'h00, 9'h165,9'h1EF,0,0,8'd1);
    add(0,0,0,0,0,8'h00, 9'h165,9'h1EF,0,0,8'd1);
    add(0,0,0,0,0,8'h00, 9'h165,9'h1EF,0,1,8'd1);
    add(1,0,0,0,0,8'h00, 9'h000,9'h000,0,0,8'd0);
    // sel2 together with mux1
    add(0,1,0,0,0,8'h05, 9'h000,9'h000,0,0,8'd0);
    add(0,0,1,0,0,8'h06, 9'h000,9'h000,0,0,8'd0);
    add(0,0,1,1,0,8'h06, 9'h000,9'h000,0,1,8'd0);
    add(1,0,0,0,0,8'h00, 9'h000,9'h000,0,0,8'd0);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].s1, tbl[i].s2, tbl[i].m, tbl[i].d, tbl[i].dat);
      chk("vec_res_add", w_res0, tbl[i].r0);
      chk("vec_res_sub", w_res1, tbl[i].r1);
      chk("vec_valid", {7'd0, w_v1, w_v0}, {7'd0, tbl[i].v, tbl[i].v});
      chk("vec_err", {7'd0, w_e1, w_e0}, {7'd0, tbl[i].e, tbl[i].e});
      chk("vec_cnt", {1'b0, w_c0}, {1'b0, tbl[i].c});
    end

    // 256 good sequences wrap the counter back to zero
    cyc(1,0,0,0,0,8'h00);
    for (int n = 0; n < 256; n++) begin
      cyc(0,1,0,0,0,8'($urandom));
      cyc(0,0,1,0,0,8'($urandom));
      cyc(0,0,0,1,0,8'h00);
      cyc(0,0,0,0,1,8'h00);
      cyc(0,0,0,0,0,8'h00);
      if (n == 254) chk("wrap_cnt_255", {1'b0, w_c0}, 9'd255);
    end
    chk("wrap_cnt_0", {1'b0, w_c0}, 9'd0);
    chk("wrap_err", {8'd0, w_e0}, 9'd0);

    // Random traffic biased toward legal progress
    for (int n = 0; n < 3000; n++) begin
      k  = int'($urandom_range(0, 99));
      rr = (k < 3);
      s1 = 1'b0; s2 = 1'b0; mm = 1'b0; dd = 1'b0;
      if (k < 55) begin
        case (m_ph)
          0: s1 = 1'b1;
          1: if ($urandom_range(0, 3) == 0) s1 = 1'b1; else s2 = 1'b1;
          2: if ($urandom_range(0, 3) == 0) s2 = 1'b1; else mm = 1'b1;
          3: if ($urandom_range(0, 3) == 0) mm = 1'b1; else dd = 1'b1;
          4: dd = 1'($urandom_range(0, 1));
          default: s1 = 1'b1;
        endcase
      end else if (k < 90) begin
        // idle cycle
      end else if (k < 96) begin
        case ($urandom_range(0, 3))
          0: s1 = 1'b1;
          1: s2 = 1'b1;
          2: mm = 1'b1;
          default: dd = 1'b1;
        endcase
      end else begin
        mh = 4'($urandom);
        {s1, s2, mm, dd} = mh;
      end
      cyc(rr, s1, s2, mm, dd, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
